// File: rtl/pipe_pkg.sv
// Shared types and sizing helpers for the pipe_reg_chain register pipeline.
package pipe_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STAGES = 3;

  // TWO only occurs when stages are built as 2-entry skid buffers.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  function automatic int count_width(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a single register, or a 2-entry skid buffer when PIPE_SKID_EN is defined.
// Handshake: a word moves on a clock edge only when valid && ready are both high.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output stage_state_t     state
);

  logic         go;
  logic         push;
  logic         pop;
  stage_state_t state_d;

  // Any reset, flush or freeze blocks both sides of the handshake.
  assign go        = enable && reset && !flush;
  assign out_valid = go && (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;

  // Ready depends only on local occupancy, breaking the combinational ready chain.
  assign in_ready = go && (state != TWO);
  assign out_data = head;

  always_comb begin
    state_d = state;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case ({push, pop})
        2'b10:   state_d = (state == EMPTY) ? ONE : TWO;
        2'b01:   state_d = (state == TWO) ? ONE : EMPTY;
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
    end else if (push && !pop) begin
      if (state == EMPTY) head <= in_data;
      else                tail <= in_data;
    end else if (!push && pop) begin
      head <= tail;
    end else if (push && pop) begin
      if (state == TWO) begin
        head <= tail;
        tail <= in_data;
      end else begin
        head <= in_data;
      end
    end
  end
`else
  logic [WIDTH-1:0] data_q;

  assign in_ready = go && ((state == EMPTY) || out_ready);
  assign out_data = data_q;

  always_comb begin
    state_d = state;
    if (flush)     state_d = EMPTY;
    else if (push) state_d = ONE;
    else if (pop)  state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!reset)    data_q <= '0;
    else if (push) data_q <= in_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= EMPTY;
    else        state <= state_d;
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// STAGES-deep valid/ready register pipeline with freeze, flush and occupancy count.
// Define PIPE_SKID_EN to build every stage as a 2-entry skid buffer (capacity 2*STAGES).
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
`ifdef PIPE_SKID_EN
  localparam int CAP   = 2 * STAGES,
`else
  localparam int CAP   = STAGES,
`endif
  localparam int CW    = count_width(CAP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic accept;
  logic deliver;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             s_in_valid;
    logic             s_in_ready;
    logic [WIDTH-1:0] s_in_data;
    logic             s_out_valid;
    logic             s_out_ready;
    logic [WIDTH-1:0] s_out_data;
    stage_state_t     s_state;
    logic [CW-1:0]    s_occ;

    if (k == 0) begin : g_first
      assign s_in_valid = in_valid;
      assign s_in_data  = in_data;
      assign s_occ      = CW'(s_state);
    end else begin : g_next
      assign s_in_valid = g_stage[k-1].s_out_valid;
      assign s_in_data  = g_stage[k-1].s_out_data;
      assign s_occ      = g_stage[k-1].s_occ + CW'(s_state);
    end

    if (k == STAGES - 1) begin : g_last
      assign s_out_ready = out_ready;
    end else begin : g_inner
      assign s_out_ready = g_stage[k+1].s_in_ready;
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .flush     (flush),
      .in_valid  (s_in_valid),
      .in_data   (s_in_data),
      .in_ready  (s_in_ready),
      .out_valid (s_out_valid),
      .out_data  (s_out_data),
      .out_ready (s_out_ready),
      .state     (s_state)
    );
  end

  assign in_ready  = g_stage[0].s_in_ready;
  assign out_valid = g_stage[STAGES-1].s_out_valid;
  assign out_data  = g_stage[STAGES-1].s_out_data;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset)     count <= '0;
    else if (flush) count <= '0;
    else            count <= count + CW'(accept) - CW'(deliver);
  end

  // The counter must always agree with the summed stage occupancies.
  a_count_matches_stages: assert property (
    @(posedge clk) disable iff (!reset) count == g_stage[STAGES-1].s_occ
  );

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: directed phases followed by randomized traffic.
module tb_pipe_reg_chain;

  localparam int W = 8;
  localparam int S = 3;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2 * S;
`else
  localparam int CAP = S;
`endif
  localparam int CW = $clog2(CAP + 1);

  // clock / reset / DUT
  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           acc_cyc_q[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  bit           lat_mode = 1'b0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Input-side model: record every accepted word, discard everything on flush/reset.
  always @(negedge clk) begin
    #1;
    if (!reset || flush) begin
      exp_q.delete();
      acc_cyc_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back(in_data);
      acc_cyc_q.push_back(lat_mode ? cyc + 1 : -1);
    end
  end

  // Output monitor: compare deliveries and status against the model.
  always @(negedge clk) begin
    check("count", 32'(count), 32'(exp_q.size()));
    if (!enable || flush || !reset) begin
      check("gated_in_ready", 32'(in_ready), 0);
      check("gated_out_valid", 32'(out_valid), 0);
    end
    if (exp_q.size() == 0) check("empty_out_valid", 32'(out_valid), 0);
    if (stall_prev && out_valid) check("stall_hold", 32'(out_data), 32'(stall_data));
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    if (lat_mode && reset && enable && !flush) check("thru_in_ready", 32'(in_ready), 1);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h expected no word", out_data);
      end else begin
        int acc;
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        acc = acc_cyc_q.pop_front();
        if (acc >= 0) check("latency", 32'(cyc + 1 - acc), S);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    enable    = 1'b1;
    flush     = 1'b0;
    reset     = 1'b1;
    while ((exp_q.size() != 0 || count != 0) && guard < 60) begin
      tick();
      guard++;
    end
    check("drain_done", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int n;
    logic [CW-1:0] frozen;
    reset = 1'b0; enable = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;

    // reset held two cycles with a pending input
    tick();
    tick();
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_data", 32'(out_data), 0);
    lat_mode = 1'b1;
    reset = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    repeat (S + 2) tick();

    // latency and throughput
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (S + 3) tick();
    lat_mode = 1'b0;
    drain();

    // backpressure until full
    out_ready = 1'b0;
    n = 0;
    for (int i = 1; i <= 2 * CAP + 4; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      #1;
      if (!in_ready) break;
      tick();
      n++;
    end
    check("full_words", 32'(n), CAP);
    check("full_count", 32'(count), CAP);
    check("bp_head", 32'(out_data), 32'h01);
    repeat (3) tick();
    // accept and deliver together while full
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(8'h40 + i);
      #1;
`ifndef PIPE_SKID_EN
      check("full_pass_ready", 32'(in_ready), 1);
`endif
      tick();
    end
    drain();

    // freeze mid-stream
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = W'(8'h60 + i);
      tick();
    end
    enable = 1'b0;
    in_data = 8'h70;
    #1;
    frozen = count;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("frozen_count", 32'(count), 32'(frozen));
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = W'(8'h71 + i);
      tick();
    end
    drain();

    // flush with two entries held and a pending input
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = W'(8'h80 + i);
      tick();
    end
    flush   = 1'b1;
    in_data = 8'hEE;
    #1;
    check("flush_in_ready", 32'(in_ready), 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_out_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    repeat (S + 2) tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 15) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 255) != 0);
      tick();
    end
    drain();
    check("end_empty", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
